// File: rtl/jimmy_pkg.sv
// Shared types for the jimmy teaching CPU: opcodes, FSM states, port indices
// and the 8-bit ALU used by the core.
package jimmy_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_LDI = 4'h1, OP_IN  = 4'h2, OP_OUT = 4'h3,
    OP_MOV  = 4'h4, OP_ADD = 4'h5, OP_SUB = 4'h6, OP_AND = 4'h7,
    OP_OR   = 4'h8, OP_XOR = 4'h9, OP_JMP = 4'hA, OP_JZ  = 4'hB,
    OP_JNZ  = 4'hC, OP_JC  = 4'hD, OP_HALT = 4'hE, OP_RSV = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH, ST_EXEC, ST_OPERAND, ST_HALT
  } state_e;

  localparam logic [1:0] PORT_A       = 2'd0;
  localparam logic [1:0] PORT_B       = 2'd1;
  localparam logic [1:0] PORT_PRODUCT = 2'd2;

  typedef struct packed {
    logic [7:0] res;
    logic       z;
    logic       c;
  } alu_out_t;

  // SUB reports borrow in C; logic ops clear it.
  function automatic alu_out_t alu(input opcode_e op, input logic [7:0] a,
                                   input logic [7:0] b);
    alu_out_t   o;
    logic [8:0] wide;
    o    = '0;
    wide = {1'b0, a} + {1'b0, b};
    case (op)
      OP_ADD: begin o.res = wide[7:0]; o.c = wide[8]; end
      OP_SUB: begin o.res = a - b;     o.c = (b > a); end
      OP_AND: o.res = a & b;
      OP_OR:  o.res = a | b;
      OP_XOR: o.res = a ^ b;
      default: o.res = a;
    endcase
    o.z = (o.res == 8'h00);
    return o;
  endfunction

  function automatic logic is_two_byte(input opcode_e op);
    return (op == OP_LDI) || (op == OP_JMP) || (op == OP_JZ) ||
           (op == OP_JNZ) || (op == OP_JC);
  endfunction

endpackage

// File: rtl/jimmy_system_if.sv
// I/O ports and observation buses of the jimmy CPU.
interface jimmy_system_if;
  logic [7:0] in_port_0;
  logic [7:0] in_port_1;
  logic [7:0] out_port_2;
  logic [3:0] out_strobe;
  logic [7:0] inst_address_bus;
  logic [7:0] inst_data_bus;

  modport master (input in_port_0, in_port_1,
                  output out_port_2, out_strobe, inst_address_bus, inst_data_bus);
  modport slave  (output in_port_0, in_port_1,
                  input out_port_2, out_strobe, inst_address_bus, inst_data_bus);
endinterface

// File: rtl/jimmy_system_program_memory.sv
// 256x8 synchronous program ROM holding the multiply-by-repeated-addition
// program; data_bus follows address_bus one clock edge later.
module program_memory (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] address_bus,
  output logic [7:0] data_bus
);
  logic [7:0] data_d, data_q;

  always_comb begin
    data_d = 8'h00;
    case (address_bus)
      8'h00: data_d = 8'h20;
      8'h01: data_d = 8'h25;
      8'h02: data_d = 8'h18;
      8'h03: data_d = 8'h00;
      8'h04: data_d = 8'h1C;
      8'h05: data_d = 8'h01;
      8'h06: data_d = 8'h85;
      8'h07: data_d = 8'hB0;
      8'h08: data_d = 8'h0D;
      8'h09: data_d = 8'h58;
      8'h0A: data_d = 8'h67;
      8'h0B: data_d = 8'hA0;
      8'h0C: data_d = 8'h06;
      8'h0D: data_d = 8'h3A;
      8'h0E: data_d = 8'hE0;
      default: data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) data_q <= 8'h00;
    else        data_q <= data_d;
  end

  assign data_bus = data_q;
endmodule

// File: rtl/jimmy_system.sv
// jimmy CPU core: FETCH/EXEC/OPERAND/HALT sequencer, four registers, Z/C
// flags and a registered output port with a one-cycle one-hot strobe.
module jimmy_system
  import jimmy_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  jimmy_system_if.master     io
);
  state_e     state_d, state_q;
  logic [7:0] pc_d, pc_q;
  logic [5:0] ir_d, ir_q;
  logic [7:0] regs_d [4];
  logic [7:0] regs_q [4];
  logic       z_d, z_q, c_d, c_q;
  logic [7:0] out_d, out_q;
  logic [3:0] strobe_d, strobe_q;
  logic [7:0] data_bus;

  opcode_e    op;
  logic [1:0] rd, rs;
  alu_out_t   alu_r;

  program_memory u_rom (
    .clk         (clk),
    .reset       (reset),
    .address_bus (pc_q),
    .data_bus    (data_bus)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    regs_d   = regs_q;
    z_d      = z_q;
    c_d      = c_q;
    out_d    = out_q;
    strobe_d = 4'b0000;
    op       = opcode_e'(data_bus[7:4]);
    rd       = data_bus[3:2];
    rs       = data_bus[1:0];
    alu_r    = alu(op, regs_q[rd], regs_q[rs]);

    case (state_q)
      ST_FETCH: begin
        pc_d    = pc_q + 8'd1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        if (is_two_byte(op)) begin
          ir_d    = data_bus[7:2];
          pc_d    = pc_q + 8'd1;
          state_d = ST_OPERAND;
        end else begin
          case (op)
            OP_IN: begin
              if (rs == PORT_A)      regs_d[rd] = io.in_port_0;
              else if (rs == PORT_B) regs_d[rd] = io.in_port_1;
              else                   regs_d[rd] = 8'h00;
            end
            OP_OUT: begin
              strobe_d[rs] = 1'b1;
              if (rs == PORT_PRODUCT) out_d = regs_q[rd];
            end
            OP_MOV: regs_d[rd] = regs_q[rs];
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              regs_d[rd] = alu_r.res;
              z_d        = alu_r.z;
              c_d        = alu_r.c;
            end
            OP_HALT: state_d = ST_HALT;
            default: ;
          endcase
        end
      end
      // Operand byte is on data_bus; IR carries the opcode and rd.
      ST_OPERAND: begin
        state_d = ST_FETCH;
        case (opcode_e'(ir_q[5:2]))
          OP_LDI: regs_d[ir_q[1:0]] = data_bus;
          OP_JMP: pc_d = data_bus;
          OP_JZ:  if (z_q)  pc_d = data_bus;
          OP_JNZ: if (!z_q) pc_d = data_bus;
          OP_JC:  if (c_q)  pc_d = data_bus;
          default: ;
        endcase
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_FETCH;
      pc_q     <= 8'h00;
      ir_q     <= '0;
      regs_q   <= '{default: 8'h00};
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      out_q    <= 8'h00;
      strobe_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      regs_q   <= regs_d;
      z_q      <= z_d;
      c_q      <= c_d;
      out_q    <= out_d;
      strobe_q <= strobe_d;
    end
  end

  assign io.out_port_2       = out_q;
  assign io.out_strobe       = strobe_q;
  assign io.inst_address_bus = pc_q;
  assign io.inst_data_bus    = data_bus;
endmodule

// File: tb/tb_jimmy_system.sv
// Directed bench for jimmy_system: operand/product table plus reset-state,
// mid-program reset and post-HALT quiet sequences.
module tb_jimmy_system;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  jimmy_system_if io();

  jimmy_system dut (.clk(clk), .reset(reset), .io(io));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
    int         lim;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_rst_out"},   io.out_port_2, 8'h00);
    chk({nm, "_rst_stb"},   io.out_strobe, 4'h0);
    chk({nm, "_rst_addr"},  io.inst_address_bus, 8'h00);
    chk({nm, "_rst_data"},  io.inst_data_bus, 8'h00);
  endtask

  // Waits for the product strobe, then checks pulse width, value and the
  // quiet halted state that follows.
  task automatic run_prog(input string nm, input logic [7:0] exp, input int lim);
    int         cyc = 0;
    bit         seen = 0;
    logic [7:0] prev_out = 8'h00;
    logic [7:0] addr;
    int         extra_stb = 0;
    int         addr_moves = 0;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (io.out_strobe != 4'h0) seen = 1;
      else prev_out = io.out_port_2;
    end
    chk({nm, "_strobe_seen"}, seen, 1);
    if (!seen) return;
    chk({nm, "_latency_ok"}, (cyc <= lim), 1);
    chk({nm, "_pre_stable"}, prev_out, 8'h00);
    chk({nm, "_strobe_bits"}, io.out_strobe, 4'b0100);
    chk({nm, "_product"}, io.out_port_2, exp);
    @(negedge clk);
    chk({nm, "_strobe_fall"}, io.out_strobe, 4'h0);
    chk({nm, "_post_hold"}, io.out_port_2, exp);
    repeat (2) @(negedge clk);
    addr = io.inst_address_bus;
    chk({nm, "_halt_pc"}, addr, 8'h0F);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (io.out_strobe != 4'h0) extra_stb++;
      if (io.inst_address_bus != addr) addr_moves++;
    end
    chk({nm, "_no_more_strobes"}, extra_stb, 0);
    chk({nm, "_pc_frozen"}, addr_moves, 0);
    chk({nm, "_final_out"}, io.out_port_2, exp);
  endtask

  initial begin
    vecs[0] = '{8'd3,   8'd11,  8'd33,  220};
    vecs[1] = '{8'd0,   8'd11,  8'd0,   3000};
    vecs[2] = '{8'd7,   8'd0,   8'd0,   3000};
    vecs[3] = '{8'd20,  8'd15,  8'd44,  3000};
    vecs[4] = '{8'd1,   8'd1,   8'd1,   3000};
    vecs[5] = '{8'd255, 8'd1,   8'd255, 3000};
    vecs[6] = '{8'd2,   8'd128, 8'd0,   3000};
    vecs[7] = '{8'd13,  8'd17,  8'd221, 3000};

    io.in_port_0 = 8'h00;
    io.in_port_1 = 8'h00;

    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      reset = 1'b0;
      io.in_port_0 = vecs[v].a;
      io.in_port_1 = vecs[v].b;
      repeat (3) @(negedge clk);
      chk_reset_state($sformatf("v%0d", v));
      reset = 1'b1;
      run_prog($sformatf("v%0d", v), vecs[v].exp, vecs[v].lim);
    end

    // Reset in the middle of the loop, then restart with new operands.
    begin
      int stb_before = 0;
      @(negedge clk);
      reset = 1'b0;
      io.in_port_0 = 8'd20;
      io.in_port_1 = 8'd15;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (io.out_strobe != 4'h0) stb_before++;
      end
      chk("midrst_no_early_strobe", stb_before, 0);
      chk("midrst_pc_running", (io.inst_address_bus != 8'h00), 1);
      @(posedge clk);
      #2 reset = 1'b0;
      #1 chk_reset_state("midrst_async");
      io.in_port_0 = 8'd5;
      io.in_port_1 = 8'd6;
      repeat (2) @(negedge clk);
      chk_reset_state("midrst_held");
      reset = 1'b1;
      run_prog("midrst", 8'd30, 3000);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/jimmy_system.md
# jimmy_system

8-bit accumulator-free, register-based teaching CPU with its own program ROM, running a fixed multiply-by-successive-addition program. It reads two unsigned operands from input ports 0 and 1 and writes their 8-bit product to output port 2 with a one-cycle strobe. It then halts. The block is the top of the jimmy demo design: CPU core logic plus a program_memory sub-module.

## Interface
- No parameters; all widths fixed at 8 bits.
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; core and ROM clear immediately while low.
- in_port_0  in  8  input port 0 (operand a).
- in_port_1  in  8  input port 1 (operand b).
- out_port_2  out  8  registered output port 2 (product).
- out_strobe  out  4  one-hot write strobe, bit p for port p.
- inst_address_bus  out  8  program address (equals PC), exported for observation.
- inst_data_bus  out  8  ROM data, exported for observation.

## Operation
- Registers: R0–R3 (8 bit), PC (8 bit), IR, flags Z and C.
- Instruction byte: opcode [7:4]; rd = [3:2], rs/port = [1:0]. Two-byte instructions are followed by an operand byte.
- Opcodes:
  - 0 NOP.
  - 1 LDI rd,imm (2 bytes).
  - 2 IN rd,port: ports 0/1 are read; ports 2/3 read 0.
  - 3 OUT rs,port.
  - 4 MOV rd,rs.
  - 5 ADD.
  - 6 SUB.
  - 7 AND.
  - 8 OR.
  - 9 XOR: rd = rd op rs.
  - A JMP addr.
  - B JZ.
  - C JNZ.
  - D JC: 2 bytes.
  - E HALT.
  - F reserved, executes as NOP.
- ALU: modulo 256. ADD sets C = carry-out. SUB sets C = borrow (rs > rd). Logic ops clear C. All ALU ops set Z = (result == 0). LDI, MOV and IN leave the flags unchanged.
- OUT to port 2: loads out_port_2 and pulses out_strobe[2]. OUT to ports 0, 1 or 3 only pulses the matching strobe bit.
- HALT: enters HALT state permanently; PC frozen; only reset exits.
- PC wraps 0xFF→0x00.
- ROM contents (address: byte). The program computes R2 = a×b mod 256 and outputs it once:
  - 00:20 IN R0,0
  - 01:25 IN R1,1
  - 02:18 00 LDI R2,0
  - 04:1C 01 LDI R3,1
  - 06:85 OR R1,R1
  - 07:B0 0D JZ 0D
  - 09:58 ADD R2,R0
  - 0A:67 SUB R1,R3
  - 0B:A0 06 JMP 06
  - 0D:3A OUT R2,2
  - 0E:E0 HALT
  - All other addresses hold 00.

## Timing
- ROM read is synchronous: data_bus equals mem[address_bus] one edge after the address is presented.
- FSM states: FETCH, EXEC, OPERAND, HALT.
- FETCH: address = PC. At the edge the ROM latches the byte, PC increments, and the FSM goes to EXEC.
- EXEC, one-byte opcode: executes at this edge, then goes to FETCH.
- EXEC, two-byte opcode: latches IR, PC increments, goes to OPERAND.
- OPERAND: data_bus is the operand byte. Executes (load, or PC ← addr if the branch is taken), then goes to FETCH.
- Cycle counts: one-byte instruction = 2 cycles; two-byte = 3 cycles.
- Reset values: PC=0, R0–R3=0, Z=C=0, IR=0, out_port_2=0, out_strobe=0, ROM data_bus=00, state=FETCH.
- out_port_2 and out_strobe update on the same edge. The strobe is high for exactly one cycle, and out_port_2 is stable before the strobe rises and after it falls.
- IN samples the port at its execute edge.
- Reset asserted mid-program aborts the instruction, clears all state and restarts at 0x00 after release.

## Structure
- Package jimmy_pkg holds:
  - opcode enum (4-bit),
  - FSM state enum,
  - port-index constants.
- Sub-module program_memory (clk, reset, address_bus in 8, data_bus out 8): 256×8 synchronous ROM initialized with the program above.
- Core datapath and FSM live in the top.

## Test plan
- in0=3, in1=11, release reset at 50 ns → single out_strobe[2] pulse with out_port_2=33. The pulse must occur within 2200 ns after release.
- in0=0, in1=11 → output 0; in0=7, in1=0 → output 0 (JZ taken on the first pass).
- in0=20, in1=15 → output 44 (300 mod 256); no further strobes after HALT.
- Reset held low → all outputs 0, inst_address_bus 0.
- Reset asserted during the loop, then released with new inputs 5, 6 → output 30. No stale strobe.
- After HALT, inst_address_bus is constant and out_strobe stays 0 for 100 cycles.
